choice_input_conditioner: RTL and testbench

CHOICE_INPUT_CONDITIONER -- requirements
Module: choice_input_conditioner

---
 rtl/car_select_pkg.sv | 18 +
 rtl/sync_2ff.sv | 26 ++
 rtl/choice_input_conditioner.sv | 128 ++++++++++++
 tb/tb_choice_input_conditioner.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/car_select_pkg.sv
// Shared definitions for the car-select input conditioning path.
// Holds the debounce state encoding and the default debounce length,
// so the top module and anything that inspects its state agree on them.
package car_select_pkg;

  // Debounce FSM states. The two CHK states count stable samples.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } deb_state_e;

  // Default number of consecutive stable synchronized samples needed
  // to accept a key edge.
  localparam int DEB_CYCLES_DEF = 16;

endpackage : car_select_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   Clock  - destination clock
//   Reset  - synchronous, active-high; clears both stages
//   d      - asynchronous input
//   q      - synchronized output (two Clock edges of latency)
module sync_2ff (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/choice_input_conditioner.sv
// Conditions the pushbutton and car-select switch feeding the car-state FSM.
// Both raw inputs are synchronized, the key is debounced by a four-state
// FSM, and the switch value is captured into Choice on each accepted press
// while no selection is held.
// Ports:
//   Clock       - system clock, rising edge
//   Reset       - synchronous, active-high
//   KeyRaw      - async pushbutton, 1 = pressed (bouncy)
//   SwRaw       - async car-select switch
//   Clear       - drop the latched choice on the next edge
//   Choice      - latched car selection
//   ChoiceValid - 1 while Choice holds a captured selection
//   KeyPulse    - one-cycle pulse per accepted press
//   KeyLevel    - debounced key level
module choice_input_conditioner
  import car_select_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyRaw,
  input  logic SwRaw,
  input  logic Clear,
  output logic Choice,
  output logic ChoiceValid,
  output logic KeyPulse,
  output logic KeyLevel
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  // The sample that makes the count reach DEB_CYCLES arrives while the
  // counter holds DEB_CYCLES-1; that is the decision point.
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic key_s, sw_s;

  sync_2ff u_key_sync (.Clock(Clock), .Reset(Reset), .d(KeyRaw), .q(key_s));
  sync_2ff u_sw_sync  (.Clock(Clock), .Reset(Reset), .d(SwRaw),  .q(sw_s));

  deb_state_e      state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            accept;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Every exit from a CHK state clears the counter; the >= compare keeps
  // it from ever counting past the decision point, so it cannot wrap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_n = PRESS_CHK;
          cnt_n   = CW'(1);
        end else begin
          cnt_n = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt >= LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          accept  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_n = RELEASE_CHK;
          cnt_n   = CW'(1);
        end else begin
          cnt_n = '0;
        end
      end
      RELEASE_CHK: begin
        if (key_s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt >= LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Pulse and choice latch share the accept edge. Clear beats a
  // simultaneous accept for the latch, but the pulse still fires.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      KeyPulse    <= 1'b0;
      Choice      <= 1'b0;
      ChoiceValid <= 1'b0;
    end else begin
      KeyPulse <= accept;
      if (Clear) begin
        ChoiceValid <= 1'b0;
      end else if (accept && !ChoiceValid) begin
        Choice      <= sw_s;
        ChoiceValid <= 1'b1;
      end
    end
  end

  assign KeyLevel = (state == PRESSED) || (state == RELEASE_CHK);

endmodule : choice_input_conditioner

// File: tb/tb_choice_input_conditioner.sv
// Directed bench for choice_input_conditioner with DEB_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_choice_input_conditioner;

  logic Clock = 1'b0;
  logic Reset, KeyRaw, SwRaw, Clear;
  logic Choice, ChoiceValid, KeyPulse, KeyLevel;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  choice_input_conditioner #(.DEB_CYCLES(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .KeyRaw     (KeyRaw),
    .SwRaw      (SwRaw),
    .Clear      (Clear),
    .Choice     (Choice),
    .ChoiceValid(ChoiceValid),
    .KeyPulse   (KeyPulse),
    .KeyLevel   (KeyLevel)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, required %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // n edges with no pulse and a fixed debounced level
  task automatic quiet(input string tag, input int n, input logic lvl);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_nopulse"}, KeyPulse, 1'b0);
      chk({tag, "_level"}, KeyLevel, lvl);
    end
  endtask

  // Key held from the next edge k: pulse after edge k+5 only (DEB_CYCLES=4).
  task automatic press_expect(input string tag, input logic ch, input logic vl);
    KeyRaw = 1'b1;
    quiet(tag, 5, 1'b0);
    tick();
    chk({tag, "_pulse"}, KeyPulse, 1'b1);
    chk({tag, "_choice"}, Choice, ch);
    chk({tag, "_valid"}, ChoiceValid, vl);
    chk({tag, "_level"}, KeyLevel, 1'b1);
    tick();
    chk({tag, "_pulse_end"}, KeyPulse, 1'b0);
  endtask

  task automatic release_key(input string tag);
    KeyRaw = 1'b0;
    tick(10);
    chk({tag, "_rel_level"}, KeyLevel, 1'b0);
    chk({tag, "_rel_pulse"}, KeyPulse, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; KeyRaw = 1'b0; SwRaw = 1'b0; Clear = 1'b0;
    tick(2);
    chk("reset_choice", Choice, 1'b0);
    chk("reset_valid", ChoiceValid, 1'b0);
    chk("reset_pulse", KeyPulse, 1'b0);
    chk("reset_level", KeyLevel, 1'b0);

    // Clean press: key sampled first at edge 10, pulse after edge 15.
    Reset = 1'b0; SwRaw = 1'b1;
    tick(7);
    press_expect("clean", 1'b1, 1'b1);

    // Two-sample release glitch while pressed: level holds, no new pulse.
    KeyRaw = 1'b0;
    quiet("glitch_lo", 2, 1'b1);
    KeyRaw = 1'b1;
    quiet("glitch_hi", 8, 1'b1);
    release_key("glitch");

    // Bounce for 10 cycles, then hold: one pulse 5 edges after hold starts.
    for (int i = 0; i < 10; i++) begin
      KeyRaw = (i % 2 == 0);
      tick();
      chk("bounce_nopulse", KeyPulse, 1'b0);
      chk("bounce_level", KeyLevel, 1'b0);
    end
    press_expect("bounce", 1'b1, 1'b1);

    // Second press with the switch flipped: choice stays frozen at 1.
    SwRaw = 1'b0;
    release_key("bounce");
    press_expect("second", 1'b1, 1'b1);

    // Clear, then a third press captures the new switch value.
    release_key("second");
    Clear = 1'b1;
    tick();
    chk("clear_valid", ChoiceValid, 1'b0);
    chk("clear_choice", Choice, 1'b1);
    Clear = 1'b0;
    press_expect("third", 1'b0, 1'b1);

    // Clear on the accept edge with nothing latched: pulse, but no load.
    release_key("third");
    SwRaw = 1'b1;
    Clear = 1'b1;
    tick();
    chk("preclear_valid", ChoiceValid, 1'b0);
    Clear = 1'b0;
    KeyRaw = 1'b1;
    quiet("clracc", 5, 1'b0);
    Clear = 1'b1;
    tick();
    chk("clracc_pulse", KeyPulse, 1'b1);
    chk("clracc_valid", ChoiceValid, 1'b0);
    chk("clracc_choice", Choice, 1'b0);
    Clear = 1'b0;
    tick();
    chk("clracc_pulse_end", KeyPulse, 1'b0);

    // With nothing latched, the next accept loads the switch.
    release_key("clracc");
    press_expect("reload", 1'b1, 1'b1);

    // Reset mid-debounce (in PRESS_CHK) with Clear also high, key held.
    release_key("reload");
    KeyRaw = 1'b1;
    tick(3);
    Reset = 1'b1; Clear = 1'b1;
    tick();
    chk("midrst_choice", Choice, 1'b0);
    chk("midrst_valid", ChoiceValid, 1'b0);
    chk("midrst_pulse", KeyPulse, 1'b0);
    chk("midrst_level", KeyLevel, 1'b0);
    Reset = 1'b0; Clear = 1'b0;
    press_expect("postrst", 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_choice_input_conditioner
